// File: rtl/vdcorput_pkg.sv
// Shared types and constants for the Van der Corput generator.
// Optional base 5 is controlled by VDCORPUT_BASE5_EN.
package vdcorput_pkg;

  localparam int FRAC_BITS_DEF = 16;
  localparam int ACC_W_DEF     = 36;

  localparam int BASE2 = 2;
  localparam int BASE3 = 3;
  localparam int BASE7 = 7;
  localparam int BASE5 = 5;

  localparam logic [1:0] SEL_B2 = 2'b00;
  localparam logic [1:0] SEL_B3 = 2'b01;
  localparam logic [1:0] SEL_B7 = 2'b10;
  localparam logic [1:0] SEL_B5 = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGIT,
    S_FRAC,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    B2,
    B3,
    B7,
    B5
  } base_t;

  // Map the external selector onto an internal base code.
  // Without base 5 support the top encoding falls back to base 2.
  function automatic base_t decode_sel(input logic [1:0] sel);
    base_t b;
    b = B2;
    unique case (1'b1)
      (sel == SEL_B3): b = B3;
      (sel == SEL_B7): b = B7;
`ifdef VDCORPUT_BASE5_EN
      (sel == SEL_B5): b = B5;
`else
      (sel == SEL_B5): b = B2;
`endif
      default:         b = B2;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vdc_digit_step.sv
// One radix-b digit extraction: quotient and remainder of k by b.
// Base 5 path exists only when VDCORPUT_BASE5_EN is defined.
module vdc_digit_step
  import vdcorput_pkg::*;
(
  input  logic [31:0] k,
  input  base_t       b,
  output logic [31:0] q,
  output logic [2:0]  r
);

  logic [31:0] q3;
  logic [31:0] r3;
  logic [31:0] q7;
  logic [31:0] r7;

  assign q3 = k / 32'd3;
  assign r3 = k - (q3 * 32'd3);
  assign q7 = k / 32'd7;
  assign r7 = k - (q7 * 32'd7);

`ifdef VDCORPUT_BASE5_EN
  logic [31:0] q5;
  logic [31:0] r5;

  assign q5 = k / 32'd5;
  assign r5 = k - (q5 * 32'd5);
`endif

  // Select the digit path; base 2 is a plain shift.
  always_comb begin
    q = {1'b0, k[31:1]};
    r = {2'b00, k[0]};
    case (b)
      B3: begin
        q = q3;
        r = r3[2:0];
      end
      B7: begin
        q = q7;
        r = r7[2:0];
      end
`ifdef VDCORPUT_BASE5_EN
      B5: begin
        q = q5;
        r = r5[2:0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/vdcorput_fsm_32bit_simple.sv
// Sequential Van der Corput radical-inverse engine, 16.16 output.
// Define VDCORPUT_BASE5_EN to make base_sel=11 select base 5.
module vdcorput_fsm_32bit_simple
  import vdcorput_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] k_in,
  input  logic [1:0]  base_sel,
  output logic [31:0] result,
  output logic        done,
  output logic        ready
);

  localparam int IW = $clog2(FRAC_BITS);
  localparam logic [IW-1:0] ITER_LAST = IW'(FRAC_BITS - 1);

  state_t               state;
  base_t                b;
  logic [31:0]          k_rem;
  logic [ACC_W-1:0]     num;
  logic [ACC_W-1:0]     den;
  logic [ACC_W-1:0]     rem;
  logic [FRAC_BITS-1:0] q;
  logic [IW-1:0]        iter;

  logic [31:0]          dq;
  logic [2:0]           dr;
  logic [ACC_W:0]       rem_sh;
  logic [ACC_W:0]       rem_sub;
  logic                 rem_ge;
  logic [FRAC_BITS-1:0] q_next;

  // Multiply by the active base using shift-add only.
  function automatic logic [ACC_W-1:0] mul_b(
    input logic [ACC_W-1:0] x,
    input base_t            bb
  );
    logic [ACC_W-1:0] y;
    y = x << 1;
    case (bb)
      B3: y = (x << 1) + x;
      B7: y = (x << 3) - x;
`ifdef VDCORPUT_BASE5_EN
      B5: y = (x << 2) + x;
`endif
      default: y = x << 1;
    endcase
    return y;
  endfunction

  vdc_digit_step u_digit (
    .k (k_rem),
    .b (b),
    .q (dq),
    .r (dr)
  );

  assign ready   = (state == S_IDLE);
  assign rem_sh  = {rem, 1'b0};
  assign rem_ge  = (rem_sh >= {1'b0, den});
  assign rem_sub = rem_sh - {1'b0, den};
  assign q_next  = {q[FRAC_BITS-2:0], rem_ge};

  // Control FSM with digit accumulation and restoring divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      b      <= B2;
      k_rem  <= '0;
      num    <= '0;
      den    <= '0;
      rem    <= '0;
      q      <= '0;
      iter   <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            k_rem <= k_in;
            b     <= decode_sel(base_sel);
            num   <= '0;
            den   <= ACC_W'(1);
            state <= S_DIGIT;
          end
        end
        S_DIGIT: begin
          if (k_rem != 32'd0) begin
            num   <= mul_b(num, b) + ACC_W'(dr);
            den   <= mul_b(den, b);
            k_rem <= dq;
          end else begin
            rem   <= num;
            q     <= '0;
            iter  <= '0;
            state <= S_FRAC;
          end
        end
        S_FRAC: begin
          if (rem_ge) begin
            rem <= rem_sub[ACC_W-1:0];
          end else begin
            rem <= rem_sh[ACC_W-1:0];
          end
          q    <= q_next;
          iter <= iter + 1'b1;
          if (iter == ITER_LAST) begin
            result <= {{(32-FRAC_BITS){1'b0}}, q_next};
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdcorput_fsm_32bit_simple.sv
// Directed scoreboard bench for the Van der Corput engine.
// Expected results are queued at start and popped on done.
module tb_vdcorput_fsm_32bit_simple;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] k_in;
  logic [1:0]  base_sel;
  logic [31:0] result;
  logic        done;
  logic        ready;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  vdcorput_fsm_32bit_simple dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_in     (k_in),
    .base_sel (base_sel),
    .result   (result),
    .done     (done),
    .ready    (ready)
  );

  function automatic logic [31:0] ref_vdc(input logic [31:0] k, input int b);
    longint unsigned num, den, kk, bb;
    num = 0;
    den = 1;
    kk  = 64'(k);
    bb  = 64'(b);
    while (kk != 0) begin
      num = num * bb + kk % bb;
      den = den * bb;
      kk  = kk / bb;
    end
    return 32'((num << 16) / den);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] k, input logic [1:0] sel,
                     input logic [31:0] exp, input int lat);
    int cyc;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(ready), 32'd1);
    start    = 1'b1;
    k_in     = k;
    base_sel = sel;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    chk(tag, result, sb.pop_front());
    chk({tag, "_busy"}, 32'(ready), 32'd0);
    if (lat >= 0) chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(ready), 32'd1);
    last_res = exp;
  endtask

  logic [31:0] exp2[6] = '{32'h8000, 32'h4000, 32'hC000, 32'h2000, 32'hA000, 32'hD000};
  logic [31:0] exp3[6] = '{32'h5555, 32'hAAAA, 32'h1C71, 32'h71C7, 32'hC71C, 32'hB425};
  logic [31:0] exp7[6] = '{32'h2492, 32'h4924, 32'h6DB6, 32'h9249, 32'hB6DB, 32'h9782};
  logic [31:0] ks[6]   = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd11};

  initial begin
    int cyc;
    int npulse;
    rst      = 1'b1;
    start    = 1'b0;
    k_in     = '0;
    base_sel = '0;
    last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run($sformatf("b2_k%0d", ks[i]), ks[i], 2'b00, exp2[i], -1);
    for (int i = 0; i < 6; i++) run($sformatf("b3_k%0d", ks[i]), ks[i], 2'b01, exp3[i], -1);
    for (int i = 0; i < 6; i++) run($sformatf("b7_k%0d", ks[i]), ks[i], 2'b10, exp7[i], -1);

    run("k0", 32'd0, 2'b00, 32'd0, 17);
    run("b2_k5_lat", 32'd5, 2'b00, 32'hA000, 20);
    repeat (3) @(posedge clk);
    #1;
    chk("hold", result, last_res);

    run("b3_kmax", 32'hFFFF_FFFF, 2'b01, ref_vdc(32'hFFFF_FFFF, 3), 21 + 17);
`ifdef VDCORPUT_BASE5_EN
    run("sel11_k1", 32'd1, 2'b11, 32'h3333, -1);
`else
    run("sel11_k1", 32'd1, 2'b11, 32'h8000, -1);
`endif

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    start    = 1'b1;
    k_in     = 32'd3;
    base_sel = 2'b00;
    sb.push_back(32'hC000);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start    = 1'b1;
    k_in     = 32'd1;
    base_sel = 2'b10;
    @(negedge clk);
    start  = 1'b0;
    npulse = 0;
    cyc    = 0;
    while (cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        npulse++;
        if (npulse == 1) chk("busy_result", result, sb.pop_front());
      end
    end
    chk("busy_pulses", 32'(npulse), 32'd1);
    if (npulse == 0) void'(sb.pop_front());

    // Reset in the middle of the fraction phase.
    @(negedge clk);
    start    = 1'b1;
    k_in     = 32'd0;
    base_sel = 2'b00;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_result", result, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    npulse = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) npulse++;
    end
    chk("abort_nopulse", 32'(npulse), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
